// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer/level width functions, default threshold constants
// and the per-edge operation encoding used by sync_fifo and async_fifo successors.
package fifo_pkg;

  localparam int unsigned AFULL_MARGIN          = 2;
  localparam int unsigned DEFAULT_AEMPTY_THRESH = 2;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WR    = 2'b01,
    OP_RD    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one write port, one registered read port with enable, no reset.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_q
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and level-decoded status flags.
// Optional sticky overflow/underflow outputs when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned AFULL_THRESH  = DEPTH - AFULL_MARGIN,
  parameter int unsigned AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_full,
  output logic                          wr_almost_full,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          rd_empty,
  output logic                          rd_almost_empty,
  output logic [level_width(DEPTH)-1:0] level
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                          overflow,
  output logic                          underflow
`endif
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  wr_accept, rd_accept;
  logic                  rd_loaded;
  logic [DATA_WIDTH-1:0] mem_q;
  fifo_op_e              op;

  assign wr_full         = (level == LW'(DEPTH));
  assign rd_empty        = (level == '0);
  assign wr_almost_full  = (level >= LW'(AFULL_THRESH));
  assign rd_almost_empty = (level <= LW'(AEMPTY_THRESH));

  assign wr_accept = wr_en && !wr_full;
  assign rd_accept = rd_en && !rd_empty;

  always_comb begin
    op = OP_IDLE;
    unique case ({rd_accept, wr_accept})
      2'b01:   op = OP_WR;
      2'b10:   op = OP_RD;
      2'b11:   op = OP_WR_RD;
      default: op = OP_IDLE;
    endcase
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(PW)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_accept),
    .wr_addr(wr_ptr),
    .wr_data(wr_data),
    .rd_en  (rd_accept),
    .rd_addr(rd_ptr),
    .rd_q   (mem_q)
  );

  // Storage has no reset, so rd_data reads as zero until the first load after reset.
  assign rd_data = rd_loaded ? mem_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rd_valid  <= 1'b0;
      rd_loaded <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) rd_loaded <= 1'b1;
      if (wr_accept) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (rd_accept) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case (op)
        OP_WR:   level <= level + LW'(1);
        OP_RD:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && wr_full)  overflow  <= 1'b1;
      if (rd_en && rd_empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: DEPTH=4 instance for flags/corner cases, DEPTH=5 for wrap order.
module tb_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic       rst4 = 1'b1, wr_en4 = 1'b0, rd_en4 = 1'b0;
  logic [7:0] wr_data4 = '0, rd_data4;
  logic       wr_full4, wr_afull4, rd_valid4, rd_empty4, rd_aempty4;
  logic [2:0] level4;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow4, underflow4;
`endif

  // DEPTH=5 instance
  logic       rst5 = 1'b1, wr_en5 = 1'b0, rd_en5 = 1'b0;
  logic [7:0] wr_data5 = '0, rd_data5;
  logic       wr_full5, wr_afull5, rd_valid5, rd_empty5, rd_aempty5;
  logic [2:0] level5;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow5, underflow5;
`endif

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .wr_en(wr_en4), .wr_data(wr_data4),
    .wr_full(wr_full4), .wr_almost_full(wr_afull4),
    .rd_en(rd_en4), .rd_data(rd_data4), .rd_valid(rd_valid4),
    .rd_empty(rd_empty4), .rd_almost_empty(rd_aempty4), .level(level4)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(overflow4), .underflow(underflow4)
`endif
  );

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst(rst5), .wr_en(wr_en5), .wr_data(wr_data5),
    .wr_full(wr_full5), .wr_almost_full(wr_afull5),
    .rd_en(rd_en5), .rd_data(rd_data5), .rd_valid(rd_valid5),
    .rd_empty(rd_empty5), .rd_almost_empty(rd_aempty5), .level(level5)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(overflow5), .underflow(underflow5)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [2:0] lvl, input logic full,
                      input logic afull, input logic empty, input logic aempty);
    check({tag, ".level"},  32'(level4),     32'(lvl));
    check({tag, ".full"},   32'(wr_full4),   32'(full));
    check({tag, ".afull"},  32'(wr_afull4),  32'(afull));
    check({tag, ".empty"},  32'(rd_empty4),  32'(empty));
    check({tag, ".aempty"}, 32'(rd_aempty4), 32'(aempty));
  endtask

  task automatic wr4(input logic [7:0] d);
    wr_en4 = 1'b1; wr_data4 = d; rd_en4 = 1'b0;
    step();
    wr_en4 = 1'b0;
  endtask

  task automatic rd4(input string tag, input logic [7:0] d);
    rd_en4 = 1'b1; wr_en4 = 1'b0;
    step();
    rd_en4 = 1'b0;
    check({tag, ".valid"}, 32'(rd_valid4), 32'd1);
    check({tag, ".data"},  32'(rd_data4),  32'(d));
  endtask

  initial begin
    // ---------------- reset state (DEPTH=4) ----------------
    step(); step();
    rst4 = 1'b0;
    chk4("reset", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("reset.valid", 32'(rd_valid4), 32'd0);
    check("reset.data",  32'(rd_data4),  32'd0);

    // ---------------- fill A,B,C,D ----------------
    wr4(8'hA1); chk4("w1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    wr4(8'hB2); chk4("w2", 3'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    wr4(8'hC3); chk4("w3", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    wr4(8'hD4); chk4("w4", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    wr4(8'hE5); chk4("w5_rejected", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);

    // ---------------- full + simultaneous read/write ----------------
    wr_en4 = 1'b1; wr_data4 = 8'hEE; rd_en4 = 1'b1;
    step();
    wr_en4 = 1'b0; rd_en4 = 1'b0;
    check("full_rw.level", 32'(level4),    32'd3);
    check("full_rw.valid", 32'(rd_valid4), 32'd1);
    check("full_rw.data",  32'(rd_data4),  32'hA1);
    step();
    check("idle.valid", 32'(rd_valid4), 32'd0);
    check("idle.hold",  32'(rd_data4),  32'hA1);

    rd4("r2", 8'hB2);
    rd4("r3", 8'hC3);
    rd4("r4", 8'hD4);
    chk4("drained", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // read when empty is rejected
    rd_en4 = 1'b1;
    step();
    rd_en4 = 1'b0;
    check("empty_rd.valid", 32'(rd_valid4), 32'd0);
    check("empty_rd.hold",  32'(rd_data4),  32'hD4);
    check("empty_rd.level", 32'(level4),    32'd0);

    // ---------------- empty + simultaneous read/write ----------------
    wr_en4 = 1'b1; wr_data4 = 8'h55; rd_en4 = 1'b1;
    step();
    wr_en4 = 1'b0; rd_en4 = 1'b0;
    check("empty_rw.level", 32'(level4),    32'd1);
    check("empty_rw.valid", 32'(rd_valid4), 32'd0);
    rd4("empty_rw.next", 8'h55);
    check("empty_rw.level0", 32'(level4), 32'd0);

    // ---------------- reset mid-operation ----------------
    wr4(8'h11); wr4(8'h22); wr4(8'h33);
    check("pre_rst.level", 32'(level4), 32'd3);
    rst4 = 1'b1; wr_en4 = 1'b1; wr_data4 = 8'h44;
    step();
    rst4 = 1'b0; wr_en4 = 1'b0;
    chk4("mid_rst", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mid_rst.valid", 32'(rd_valid4), 32'd0);
    check("mid_rst.data",  32'(rd_data4),  32'd0);
    step();
    check("post_rst.level", 32'(level4), 32'd0);
    wr4(8'h66);
    rd4("post_rst.rd", 8'h66);

    // ---------------- DEPTH=5 interleaved wrap ----------------
    begin
      int w = 0, r = 0, cnt = 0;
      step();
      rst5 = 1'b0;
      check("d5.reset.level", 32'(level5), 32'd0);
      for (int k = 0; k < 40 && r < 12; k++) begin
        logic we, re;
        we = (w < 12) && (cnt < 5) && (k % 4 != 3);
        re = (cnt > 0) && (k % 4 != 0);
        wr_en5 = we; rd_en5 = re; wr_data5 = 8'(w);
        step();
        if (we) begin w++; cnt++; end
        if (re) begin
          check("d5.valid", 32'(rd_valid5), 32'd1);
          check("d5.data",  32'(rd_data5),  32'(r));
          r++; cnt--;
        end
        check("d5.level", 32'(level5), 32'(cnt));
      end
      wr_en5 = 1'b0; rd_en5 = 1'b0;
      check("d5.reads_done", 32'(r), 32'd12);
      check("d5.empty", 32'(rd_empty5), 32'd1);
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // ---------------- sticky error flags ----------------
    rst4 = 1'b1; step(); rst4 = 1'b0;
    check("err.rst.ovf", 32'(overflow4),  32'd0);
    check("err.rst.udf", 32'(underflow4), 32'd0);
    wr4(8'h01); wr4(8'h02); wr4(8'h03); wr4(8'h04);
    check("err.full.ovf", 32'(overflow4), 32'd0);
    wr4(8'h05);
    check("err.ovf_set", 32'(overflow4), 32'd1);
    for (int i = 0; i < 10; i++) step();
    check("err.ovf_held", 32'(overflow4),  32'd1);
    check("err.udf_clr",  32'(underflow4), 32'd0);
    rst4 = 1'b1; step(); rst4 = 1'b0;
    rd_en4 = 1'b1; step(); rd_en4 = 1'b0;
    check("err.udf_set", 32'(underflow4), 32'd1);
    check("err.ovf_rst", 32'(overflow4),  32'd0);
    rst4 = 1'b1; step(); rst4 = 1'b0;
    check("err.udf_rst", 32'(underflow4), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the entry width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, SHALL set the entry count; any value >=2 is legal, power-of-two not required.
REQ-003 Parameter AFULL_THRESH, default DEPTH-2, SHALL set the almost-full level (1..DEPTH).
REQ-004 Parameter AEMPTY_THRESH, default 2, SHALL set the almost-empty level (0..DEPTH-1).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with the ports listed below.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 wr_en  in  1  write request.
REQ-009 wr_data  in  DATA_WIDTH  write data.
REQ-010 wr_full  out  1  high when level==DEPTH.
REQ-011 wr_almost_full  out  1  high when level>=AFULL_THRESH.
REQ-012 rd_en  in  1  read request.
REQ-013 rd_data  out  DATA_WIDTH  registered read data.
REQ-014 rd_valid  out  1  one-cycle pulse marking rd_data as newly loaded.
REQ-015 rd_empty  out  1  high when level==0.
REQ-016 rd_almost_empty  out  1  high when level<=AEMPTY_THRESH.
REQ-017 level  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Function
REQ-018 A write SHALL be accepted iff wr_en && !wr_full; the entry is stored at wr_ptr, and wr_ptr advances.
REQ-019 A read SHALL be accepted iff rd_en && !rd_empty; mem[rd_ptr] is loaded into rd_data on the same edge, rd_valid is 1 the next cycle, and rd_ptr advances.
REQ-020 Read latency SHALL be exactly 1 cycle; rd_data SHALL hold its last value when no read is accepted.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0 by explicit compare, not by bit overflow.
REQ-022 Level SHALL change by +1 on write only, by -1 on read only, and stay unchanged on simultaneous accepted read and write.
REQ-023 All status flags SHALL be combinational decodes of the registered level, so they reflect state before the current edge.
REQ-024 When full and both wr_en and rd_en are high: the read SHALL be accepted, the write rejected, and the new level is DEPTH-1.
REQ-025 When empty and both are high: the write SHALL be accepted, the read rejected (no fall-through), and the new level is 1.
REQ-026 A rejected write SHALL leave memory, wr_ptr and level unchanged; a rejected read SHALL leave rd_data and rd_ptr unchanged and give rd_valid=0.
REQ-027 Data SHALL emerge in strict write order across any number of pointer wraps.

Reset
REQ-028 On rst: wr_ptr=0, rd_ptr=0, level=0, rd_data=0, rd_valid=0; this gives wr_full=0, rd_empty=1, rd_almost_empty=1, and wr_almost_full=0.
REQ-029 Reset SHALL take priority over concurrent wr_en/rd_en; in-flight data is discarded and memory contents are not cleared.
REQ-030 Reset asserted mid-operation SHALL produce the REQ-028 state on the following cycle regardless of prior level.

Configuration
REQ-031 With macro SYNC_FIFO_ERR_FLAGS_EN defined, the block SHALL add outputs overflow (1) and underflow (1).
REQ-032 overflow SHALL set on wr_en && wr_full, underflow SHALL set on rd_en && rd_empty, and both SHALL be sticky until rst.
REQ-033 Without SYNC_FIFO_ERR_FLAGS_EN, these ports and their logic SHALL be absent, and rejection behaviour SHALL be unchanged.

Structure
REQ-034 Package fifo_pkg SHALL hold the ptr/level width helper functions and the default threshold constants, shared with async_fifo successors.
REQ-035 Storage SHALL be a sub-module fifo_mem (1 write port, 1 registered read port, no reset), instantiated once.

Verification
REQ-036 DEPTH=4: write A,B,C,D -> wr_full=1, level=4, wr_almost_full=1 from level 2; 5th write ignored; reads return A,B,C,D, each rd_valid 1 cycle after rd_en.
REQ-037 DEPTH=5 (non-pow2): 12 writes interleaved with reads, values 0..11 -> output 0..11 in order, pointers wrap correctly.
REQ-038 Full plus simultaneous rd_en/wr_en with wr_data=0xEE -> level 4->3, 0xEE not stored, oldest entry read.
REQ-039 Empty plus simultaneous rd_en/wr_en with 0x55 -> level 0->1, rd_valid=0; next read returns 0x55.
REQ-040 Level 3 then rst for 1 cycle with wr_en=1 -> level=0, rd_empty=1, rd_valid=0, rd_data=0 next cycle.
REQ-041 With SYNC_FIFO_ERR_FLAGS_EN: write when full -> overflow=1 and held across 10 idle cycles; read when empty -> underflow=1; rst clears both.
